fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 16, max cycles waiting for mem_gnt or mem_rvalid before error.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 fetch_start  in  1  controller request to fetch the instruction at pc.
REQ-006 pc_write  in  1  update pc this cycle per pc_source.
REQ-007 pc_source  in  2  00 pc+4, 01 alu_result, 10 alu_result with bit0 cleared (jalr), 11 hold.
REQ-008 alu_result  in  32  computed next-PC / branch target.
REQ-009 mem_req  out  1  instruction memory request strobe.
REQ-010 mem_addr  out  32  word address of the request, equal to pc latched at fetch start.
REQ-011 mem_gnt  in  1  memory accepted the request.
REQ-012 mem_rvalid  in  1  mem_rdata valid this cycle.
REQ-013 mem_rdata  in  32  fetched instruction word.
REQ-014 pc  out  32  current program counter.
REQ-015 ir  out  32  instruction register.
REQ-016 opcode  out  7  ir[6:0]; funct3 out 3 ir[14:12]; funct7 out 7 ir[31:25].
REQ-017 instr_valid  out  1  one-cycle pulse when ir is newly loaded.
REQ-018 fetch_busy  out  1  high in any state other than IDLE and ERROR.
REQ-019 fetch_error  out  2  00 none, 01 misaligned pc, 10 grant timeout, 11 data timeout; sticky.

Function
REQ-020 States: IDLE, REQ, WAIT, ERROR; one-hot encoded.
REQ-021 IDLE: on fetch_start with pc[1:0]==00, latch mem_addr=pc and go to REQ; on fetch_start with pc[1:0]!=00, set fetch_error=01 and go to ERROR.
REQ-022 REQ: mem_req=1 and mem_addr held stable until mem_gnt; on mem_gnt go to WAIT and clear the timeout counter.
REQ-023 WAIT: mem_req=0; on mem_rvalid load ir<=mem_rdata, pulse instr_valid next cycle, return to IDLE.
REQ-024 mem_gnt and mem_rvalid in the same REQ cycle: treat as grant plus data; ir loaded, return to IDLE, WAIT skipped.
REQ-025 Minimum latency fetch_start to instr_valid: 2 cycles (1 if REQ-024 applies).
REQ-026 Timeout counter, clog2(TIMEOUT+1) bits, increments each cycle in REQ or WAIT without the awaited event; on reaching TIMEOUT: fetch_error=10 (REQ) or 11 (WAIT), go to ERROR.
REQ-027 ERROR: mem_req=0, outputs held; exits only via reset.
REQ-028 ir holds its value outside WAIT-capture; fetch_start while busy is ignored.
REQ-029 pc updates only on pc_write in IDLE; pc_write while busy is ignored to protect mem_addr.
REQ-030 pc+4 arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-031 mem_rvalid in IDLE or REQ without grant is ignored (no ir load).

Reset
REQ-032 rst_n low, asynchronously: state=IDLE, pc=RESET_PC, ir=32'h0000_0013 (NOP), mem_req=0, mem_addr=RESET_PC, instr_valid=0, fetch_error=00, counter=0.
REQ-033 Reset asserted mid-fetch abandons the transaction; any mem_rvalid after reset release is ignored unless a new request was granted.

Verification
REQ-034 Reset, fetch_start, mem_gnt cycle 1, mem_rvalid cycle 2 with 32'h0010_0093 -> mem_addr=0, ir=32'h0010_0093, opcode=0010011, instr_valid pulse one cycle.
REQ-035 pc=8, pc_write with pc_source=00 -> pc=12; pc_source=10 with alu_result=32'h0000_0105 -> pc=32'h0000_0104.
REQ-036 pc forced to 32'h0000_0002 via pc_source=01, then fetch_start -> fetch_error=01, ERROR, no mem_req.
REQ-037 mem_gnt withheld 16 cycles -> fetch_error=10, mem_req drops; same for mem_rvalid -> 11.
REQ-038 mem_gnt and mem_rvalid same cycle -> instr_valid one cycle later, no WAIT visit.
REQ-039 rst_n low during WAIT, stray mem_rvalid after release -> ir remains 32'h0000_0013, state IDLE.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch unit bus: controller-side PC/fetch controls, instruction-memory handshake, decoded outputs.
// Latency: none (pure signal bundle).
// Backpressure: memory stalls the unit by withholding mem_gnt / mem_rvalid.
// Ports: master = fetch unit (drives mem_req/mem_addr/pc/ir/status), slave = controller + memory.
interface fetch_if;
  logic        fetch_start;
  logic        pc_write;
  logic [1:0]  pc_source;
  logic [31:0] alu_result;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        instr_valid;
  logic        fetch_busy;
  logic [1:0]  fetch_error;

  modport master (
    input  fetch_start, pc_write, pc_source, alu_result,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output mem_req, mem_addr, pc, ir, opcode, funct3, funct7,
    output instr_valid, fetch_busy, fetch_error
  );

  modport slave (
    output fetch_start, pc_write, pc_source, alu_result,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  mem_req, mem_addr, pc, ir, opcode, funct3, funct7,
    input  instr_valid, fetch_busy, fetch_error
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one instruction-memory fetch at a time, captures ir.
// Latency: fetch_start edge to instr_valid = 2 edges (1 when grant and data arrive together).
// Backpressure: waits for mem_gnt then mem_rvalid; TIMEOUT cycles without either -> sticky ERROR.
// Ports: clk, rst_n (async active-low); bus = fetch_if.master (controls, memory handshake, ir/decode, status).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input logic    clk,
  input logic    rst_n,
  fetch_if.master bus
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TO_LIMIT = CW'(TIMEOUT);
  localparam logic [31:0]     NOP      = 32'h0000_0013;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_GNT   = 2'b10;
  localparam logic [1:0] ERR_DATA  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_REQ   = 4'b0010,
    S_WAIT  = 4'b0100,
    S_ERROR = 4'b1000
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic          iv_q, iv_d;
  logic [1:0]    err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    addr_d  = addr_q;
    req_d   = req_q;
    iv_d    = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        // PC may only move while idle so the in-flight mem_addr is never disturbed.
        if (bus.pc_write) begin
          case (bus.pc_source)
            2'b00:   pc_d = pc_q + 32'd4;
            2'b01:   pc_d = bus.alu_result;
            2'b10:   pc_d = {bus.alu_result[31:1], 1'b0};
            default: pc_d = pc_q;
          endcase
        end
        if (bus.fetch_start) begin
          if (pc_q[1:0] == 2'b00) begin
            addr_d  = pc_q;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_REQ;
          end else begin
            err_d   = ERR_ALIGN;
            state_d = S_ERROR;
          end
        end
      end

      S_REQ: begin
        if (bus.mem_gnt) begin
          req_d = 1'b0;
          cnt_d = '0;
          // Grant and data in the same cycle: capture now and skip WAIT.
          if (bus.mem_rvalid) begin
            ir_d    = bus.mem_rdata;
            iv_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (cnt_inc == TO_LIMIT) begin
          req_d   = 1'b0;
          cnt_d   = cnt_inc;
          err_d   = ERR_GNT;
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WAIT: begin
        if (bus.mem_rvalid) begin
          ir_d    = bus.mem_rdata;
          iv_d    = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_inc == TO_LIMIT) begin
          cnt_d   = cnt_inc;
          err_d   = ERR_DATA;
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_ERROR: begin
        // Terminal until reset; everything holds.
      end

      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= NOP;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      iv_q    <= 1'b0;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      iv_q    <= iv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_req     = req_q;
  assign bus.mem_addr    = addr_q;
  assign bus.pc          = pc_q;
  assign bus.ir          = ir_q;
  assign bus.opcode      = ir_q[6:0];
  assign bus.funct3      = ir_q[14:12];
  assign bus.funct7      = ir_q[31:25];
  assign bus.instr_valid = iv_q;
  assign bus.fetch_busy  = (state_q == S_REQ) || (state_q == S_WAIT);
  assign bus.fetch_error = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, normal fetch, PC updates, misalignment, timeouts, reset mid-fetch.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: memory grant/data driven directly by the step sequence.
module tb_fetch_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fetch_if bus_if ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus_if.fetch_start = 1'b0;
    bus_if.pc_write    = 1'b0;
    bus_if.pc_source   = 2'b00;
    bus_if.alu_result  = 32'h0;
    bus_if.mem_gnt     = 1'b0;
    bus_if.mem_rvalid  = 1'b0;
    bus_if.mem_rdata   = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_pc",       bus_if.pc,          32'h0);
    check("rst_ir",       bus_if.ir,          32'h0000_0013);
    check("rst_mem_req",  bus_if.mem_req,     32'h0);
    check("rst_mem_addr", bus_if.mem_addr,    32'h0);
    check("rst_iv",       bus_if.instr_valid, 32'h0);
    check("rst_err",      bus_if.fetch_error, 32'h0);
    check("rst_busy",     bus_if.fetch_busy,  32'h0);
    rst_n = 1'b1;
    tick();

    // Normal fetch: grant next cycle, data the cycle after
    bus_if.fetch_start = 1'b1;
    tick();
    check("f1_req",  bus_if.mem_req,    32'h1);
    check("f1_addr", bus_if.mem_addr,   32'h0);
    check("f1_busy", bus_if.fetch_busy, 32'h1);
    bus_if.fetch_start = 1'b0;
    bus_if.mem_gnt     = 1'b1;
    bus_if.pc_write    = 1'b1;   // ignored while busy
    bus_if.pc_source   = 2'b00;
    tick();
    check("f1_wait_req",  bus_if.mem_req,    32'h0);
    check("f1_wait_busy", bus_if.fetch_busy, 32'h1);
    check("f1_pc_hold",   bus_if.pc,         32'h0);
    check("f1_iv_early",  bus_if.instr_valid, 32'h0);
    bus_if.mem_gnt    = 1'b0;
    bus_if.pc_write   = 1'b0;
    bus_if.mem_rvalid = 1'b1;
    bus_if.mem_rdata  = 32'h0010_0093;
    tick();
    check("f1_ir",     bus_if.ir,          32'h0010_0093);
    check("f1_opcode", bus_if.opcode,      32'h13);
    check("f1_iv",     bus_if.instr_valid, 32'h1);
    check("f1_idle",   bus_if.fetch_busy,  32'h0);
    bus_if.mem_rvalid = 1'b0;
    tick();
    check("f1_iv_pulse", bus_if.instr_valid, 32'h0);
    check("f1_ir_hold",  bus_if.ir,          32'h0010_0093);

    // PC update sources, including wrap
    bus_if.pc_write   = 1'b1;
    bus_if.pc_source  = 2'b01;
    bus_if.alu_result = 32'h0000_0008;
    tick();
    check("pc_alu", bus_if.pc, 32'h0000_0008);
    bus_if.pc_source = 2'b00;
    tick();
    check("pc_plus4", bus_if.pc, 32'h0000_000C);
    bus_if.pc_source  = 2'b10;
    bus_if.alu_result = 32'h0000_0105;
    tick();
    check("pc_jalr", bus_if.pc, 32'h0000_0104);
    bus_if.pc_source = 2'b11;
    tick();
    check("pc_hold", bus_if.pc, 32'h0000_0104);
    bus_if.pc_source  = 2'b01;
    bus_if.alu_result = 32'hFFFF_FFFC;
    tick();
    bus_if.pc_source = 2'b00;
    tick();
    check("pc_wrap", bus_if.pc, 32'h0000_0000);
    bus_if.pc_write = 1'b0;

    // Grant and data together, stray rvalid before grant ignored
    bus_if.fetch_start = 1'b1;
    tick();
    bus_if.fetch_start = 1'b0;
    bus_if.mem_rvalid  = 1'b1;
    bus_if.mem_rdata   = 32'h1234_5678;
    tick();
    check("sc_nognt_req", bus_if.mem_req, 32'h1);
    check("sc_nognt_ir",  bus_if.ir,      32'h0010_0093);
    bus_if.mem_gnt   = 1'b1;
    bus_if.mem_rdata = 32'hA5A5_C0DE;
    tick();
    check("sc_iv",     bus_if.instr_valid, 32'h1);
    check("sc_ir",     bus_if.ir,          32'hA5A5_C0DE);
    check("sc_opcode", bus_if.opcode,      32'h5E);
    check("sc_funct3", bus_if.funct3,      32'h4);
    check("sc_funct7", bus_if.funct7,      32'h52);
    check("sc_busy",   bus_if.fetch_busy,  32'h0);
    check("sc_req",    bus_if.mem_req,     32'h0);
    clear_inputs();
    tick();
    check("sc_iv_pulse", bus_if.instr_valid, 32'h0);

    // Grant timeout
    do_reset();
    bus_if.fetch_start = 1'b1;
    tick();
    bus_if.fetch_start = 1'b0;
    repeat (15) tick();
    check("gto_pre_req", bus_if.mem_req,     32'h1);
    check("gto_pre_err", bus_if.fetch_error, 32'h0);
    tick();
    check("gto_err",  bus_if.fetch_error, 32'h2);
    check("gto_req",  bus_if.mem_req,     32'h0);
    check("gto_busy", bus_if.fetch_busy,  32'h0);
    bus_if.fetch_start = 1'b1;
    bus_if.pc_write    = 1'b1;
    bus_if.pc_source   = 2'b00;
    tick();
    tick();
    check("err_sticky", bus_if.fetch_error, 32'h2);
    check("err_noreq",  bus_if.mem_req,     32'h0);
    check("err_pc",     bus_if.pc,          32'h0);

    // Data timeout
    do_reset();
    bus_if.fetch_start = 1'b1;
    tick();
    bus_if.fetch_start = 1'b0;
    bus_if.mem_gnt     = 1'b1;
    tick();
    bus_if.mem_gnt = 1'b0;
    repeat (15) tick();
    check("dto_pre_busy", bus_if.fetch_busy,  32'h1);
    check("dto_pre_err",  bus_if.fetch_error, 32'h0);
    tick();
    check("dto_err",  bus_if.fetch_error, 32'h3);
    check("dto_busy", bus_if.fetch_busy,  32'h0);

    // Misaligned PC
    do_reset();
    bus_if.pc_write   = 1'b1;
    bus_if.pc_source  = 2'b01;
    bus_if.alu_result = 32'h0000_0002;
    tick();
    check("mis_pc", bus_if.pc, 32'h0000_0002);
    bus_if.pc_write    = 1'b0;
    bus_if.fetch_start = 1'b1;
    tick();
    check("mis_err", bus_if.fetch_error, 32'h1);
    check("mis_req", bus_if.mem_req,     32'h0);
    bus_if.fetch_start = 1'b0;
    tick();
    check("mis_req_hold", bus_if.mem_req,    32'h0);
    check("mis_busy",     bus_if.fetch_busy, 32'h0);

    // Reset during WAIT, stray data afterwards
    do_reset();
    bus_if.fetch_start = 1'b1;
    tick();
    bus_if.fetch_start = 1'b0;
    bus_if.mem_gnt     = 1'b1;
    tick();
    bus_if.mem_gnt = 1'b0;
    check("rw_busy", bus_if.fetch_busy, 32'h1);
    rst_n = 1'b0;
    #2;
    check("rw_async_busy", bus_if.fetch_busy, 32'h0);
    check("rw_async_err",  bus_if.fetch_error, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    bus_if.mem_rvalid = 1'b1;
    bus_if.mem_rdata  = 32'hDEAD_BEEF;
    tick();
    check("rw_ir",   bus_if.ir,          32'h0000_0013);
    check("rw_iv",   bus_if.instr_valid, 32'h0);
    check("rw_busy2", bus_if.fetch_busy, 32'h0);
    check("rw_req",  bus_if.mem_req,     32'h0);
    clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
